// File: rtl/next_pc_unit_if.sv
// Bus bundle for next_pc_unit.
//   master : fetch/decode side; drives Instruction, Branch, rs1Data, stall
//            and observes PC, PCPlus4, Redirect, MisalignErr, InstCount.
//   slave  : next_pc_unit itself.
interface next_pc_unit_if;
  logic [31:0] Instruction;
  logic        Branch;
  logic [31:0] rs1Data;
  logic        stall;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Redirect;
  logic        MisalignErr;
  logic [31:0] InstCount;

  modport master (
    output Instruction, Branch, rs1Data, stall,
    input  PC, PCPlus4, Redirect, MisalignErr, InstCount
  );

  modport slave (
    input  Instruction, Branch, rs1Data, stall,
    output PC, PCPlus4, Redirect, MisalignErr, InstCount
  );
endinterface

// File: rtl/next_pc_unit.sv
// next_pc_unit: registered RV32I program counter with next-PC selection.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus.Instruction : instruction at the current PC
//   bus.Branch      : branch-taken flag (only meaningful for SB opcodes)
//   bus.rs1Data     : JALR base operand
//   bus.stall       : freezes PC and InstCount, suppresses flags
//   bus.PC          : registered program counter
//   bus.PCPlus4     : combinational PC+4 (link value)
//   bus.Redirect    : one-cycle pulse, PC loaded with a non-sequential value
//   bus.MisalignErr : one-cycle pulse, misaligned target trapped to TRAP_PC
//   bus.InstCount   : count of non-stalled edges since reset
module next_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input logic          clk,
  input logic          rst_n,
  next_pc_unit_if.slave bus
);
  localparam logic [6:0] OP_SB   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [31:0] pc_q, cnt_q;
  logic        red_q, mis_q;

  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [31:0] imm_b, imm_j, imm_i;
  logic [31:0] pc_plus4, tgt, pc_nxt;
  logic        nonseq, misal;

  assign op     = bus.Instruction[6:0];
  assign funct3 = bus.Instruction[14:12];

  assign imm_b = {{20{bus.Instruction[31]}}, bus.Instruction[7], bus.Instruction[30:25],
                  bus.Instruction[11:8], 1'b0};
  assign imm_j = {{12{bus.Instruction[31]}}, bus.Instruction[19:12], bus.Instruction[20],
                  bus.Instruction[30:21], 1'b0};
  assign imm_i = {{20{bus.Instruction[31]}}, bus.Instruction[31:20]};

  assign pc_plus4 = pc_q + 32'd4;

  // Target priority: JAL, then JALR, then taken SB, else sequential.
  always_comb begin
    tgt    = pc_plus4;
    nonseq = 1'b0;
    if (op == OP_JAL) begin
      tgt    = pc_q + imm_j;
      nonseq = 1'b1;
    end else if (op == OP_JALR && funct3 == 3'b000) begin
      tgt    = (bus.rs1Data + imm_i) & ~32'h1;
      nonseq = 1'b1;
    end else if (op == OP_SB && bus.Branch) begin
      tgt    = pc_q + imm_b;
      nonseq = 1'b1;
    end
  end

  // Only non-sequential targets can trap; PC+4 is always word aligned.
  assign misal  = nonseq && (tgt[1:0] != 2'b00);
  assign pc_nxt = misal ? TRAP_PC : tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      red_q <= 1'b0;
      mis_q <= 1'b0;
    end else if (bus.stall) begin
      red_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      cnt_q <= cnt_q + 32'd1;
      red_q <= nonseq;
      mis_q <= misal;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.PCPlus4     = pc_plus4;
  assign bus.Redirect    = red_q;
  assign bus.MisalignErr = mis_q;
  assign bus.InstCount   = cnt_q;
endmodule
